mux_8x1_rr: RTL
===============

Name: mux_8x1_rr

Overview:
- Eight-input, one-output round-robin multiplexer with valid/ready handshakes on every channel.
- Gathers words from eight producer channels onto one registered output stream.
- Tags each output word with its 3-bit source channel number, so a downstream 1x8 demultiplexer can route the word back out by select.
- Sits at the merge end of the 8-lane data path and provides per-channel fairness and backpressure.

Parameters:
- DATA_W, 8, width of each channel's data word (minimum 1).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  8  bit i high: channel i presents a word.
- in_data  input  8*DATA_W  channel i word at in_data[i*DATA_W +: DATA_W].
- in_ready  output  8  bit i high: channel i's word is accepted this cycle (one-hot or zero).
- out_valid  output  1  output register holds a word.
- out_data  output  DATA_W  registered output word.
- out_sel  output  3  source channel of out_data (3'b000 = channel 0 ... 3'b111 = channel 7).
- out_ready  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_sel=3'b000.
  - Round-robin pointer ptr=3'b000.
  - in_ready=0 while reset is asserted.
  - Reset is honoured mid-transfer: a held word is discarded and no in_ready pulse occurs.
- Load condition: load = ~out_valid | out_ready.
- Grant:
  - When load=1 and in_valid!=0, grant channel g = the first set bit of in_valid, scanning ptr, ptr+1, ... ptr+7, wrapping mod 8.
  - in_ready is combinational: in_ready[g]=1 in that cycle; all other bits are 0.
  - When load=0 or in_valid=0, in_ready=0.
- On the clock edge with a grant:
  - out_data <= channel g word; out_sel <= g; out_valid <= 1.
  - ptr <= g+1 (3-bit wrap, 7 -> 0).
- On a load with no valid input: out_valid <= 0. out_data and out_sel hold their previous values (don't-care to consumers).
- While out_valid=1 and out_ready=0:
  - out_valid, out_data and out_sel are held stable.
  - in_ready=0 and ptr is unchanged.
- Latency: word accepted in cycle N appears on the output in cycle N+1.
- Throughput: one word per cycle when out_ready is held high (the consume and the next load happen in the same cycle, with no bubble).
- Fairness: with all eight channels continuously valid, the grant order is ptr, ptr+1, ..., and each channel is granted exactly once per 8 accepted words.
- Simultaneous requests: only the single channel chosen by the pointer scan is granted. Non-granted channels hold their valid/data (standard valid/ready rule: a producer must not drop valid before it sees ready).
- A channel whose valid deasserts before its grant is simply skipped; no state is kept per channel.
- The pointer advances only on a grant, never on idle cycles.
- in_ready does not depend on in_data; it depends combinationally only on in_valid, out_valid, out_ready and ptr.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, out_sel=0, out_data=0, in_ready=0. Release with in_valid=8'h00 -> outputs stay 0.
- Single channel: in_valid=8'b0000_1000 (ch3), word 8'hA5, out_ready=1 -> in_ready=8'b0000_1000 in that cycle. Next cycle out_valid=1, out_data=8'hA5, out_sel=3'd3. ptr becomes 4.
- Round-robin: from reset, all eight channels valid with word = channel number, out_ready=1 -> out_sel sequence 0,1,...,7,0 on consecutive cycles with no idle cycle, and out_data matches out_sel.
- Backpressure: ch5 word 8'h5C loaded, then out_ready=0 for 4 cycles while ch2 and ch6 are valid -> out_data=8'h5C and out_sel=5 are stable, in_ready=0. On out_ready=1, ch6 is granted that cycle (scan from 6).
- Wrap and skip: ptr=7, in_valid=8'b0000_0101 -> ch0 granted, then ch2 granted, then ptr=3. Deassert in_valid entirely -> out_valid drops to 0 after the last word is consumed.
- Reset mid-operation: out_valid=1, out_ready=0, rst_n pulsed low between clock edges -> out_valid=0 immediately (asynchronous), ptr=0. After release, the first grant scans from channel 0.

Source files
------------

// File: rtl/mux_8x1_rr.sv
`default_nettype none
// ============================================================================
//  Module   : mux_8x1_rr
//  Brief    : 8:1 round-robin valid/ready merge onto one registered stream,
//             each word tagged with its 3-bit source channel.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_8x1_rr #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_valid,
    input  logic [8*DATA_W-1:0]   in_data,
    output logic [7:0]            in_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [2:0]            out_sel,
    input  logic                  out_ready
);

    localparam int c_NUM_CH = 8;

    logic [DATA_W-1:0] w_chan [c_NUM_CH];
    logic              w_load;
    logic              w_any;
    logic [2:0]        w_grant;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [2:0]        r_out_sel;
    logic [2:0]        r_ptr;

    generate
        for (genvar gi = 0; gi < c_NUM_CH; gi++) begin : g_chan
            assign w_chan[gi] = in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign w_load = ~r_out_valid | out_ready;

    // First valid channel scanning upward from the pointer, wrapping mod 8.
    always_comb begin
        w_any   = 1'b0;
        w_grant = 3'd0;
        for (int k = 0; k < c_NUM_CH; k++) begin
            if (!w_any && in_valid[r_ptr + 3'(k)]) begin
                w_any   = 1'b1;
                w_grant = r_ptr + 3'(k);
            end
        end
    end

    // rst_n gating keeps in_ready low for the whole reset interval.
    assign in_ready = (rst_n && w_load && w_any) ? (8'b1 << w_grant) : 8'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= 3'd0;
            r_ptr       <= 3'd0;
        end else if (w_load) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_chan[w_grant];
                r_out_sel   <= w_grant;
                r_ptr       <= w_grant + 3'd1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
`default_nettype wire
